iic_cm: RTL and testbench

//  - Write-only I2C master: sends one 24-bit word as three bytes (MSB first) in one transaction: START, 3x(byte+ACK slot), STOP.
//  - Used to program register-mapped peripherals such as an audio codec: byte2 = device addr+W, byte1/byte0 = register/data.
//  - Runs on the 50 MHz system clock; SCL is generated from a quarter-bit tick; SDA is open-drain.

---
 rtl/iic_cm.sv | 154 +++++++++++++++
 tb/tb_iic_cm.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/iic_cm.sv
// Write-only I2C master: START, three bytes (MSB first) each followed by an ACK slot, then STOP.
// Latency: 29 bit periods from the go edge to the done pulse, plus up to one quarter-bit of alignment.
// Backpressure: none. A go edge is accepted only in IDLE; edges while busy are dropped and NACKs are ignored.
module iic_cm #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int SCL_FREQ = 100_000
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    inout  wire         iic_sdata,
    output logic        iic_sclk,
    output logic        iic_ref_clk,
    input  logic [23:0] iic_data,
    input  logic        iic_tr_go,
    output logic        iic_tr_done
);

    localparam int QDIV = CLK_FREQ / (4 * SCL_FREQ);
    localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, ACK, STOP, DONE} state_t;

    state_t        state, state_nx;
    logic [QW-1:0] qcnt;
    logic          qtick;
    logic [1:0]    quarter, quarter_nx;
    logic [2:0]    bit_cnt, bit_nx;
    logic [1:0]    byte_cnt, byte_nx;
    logic [23:0]   shreg, shreg_nx;
    logic          pending, pending_nx;
    logic          sclk_nx;
    logic          sda_low, sda_low_nx;
    logic          go_d;
    logic          go_edge;

    assign qtick       = (qcnt == QW'(QDIV - 1));
    assign go_edge     = iic_tr_go & ~go_d;
    assign iic_sdata   = sda_low ? 1'b0 : 1'bz;
    assign iic_tr_done = (state == DONE);

    always_ff @(posedge clk_50m or posedge rst_n) begin
        if (rst_n) begin
            state       <= IDLE;
            qcnt        <= '0;
            quarter     <= 2'd0;
            bit_cnt     <= 3'd7;
            byte_cnt    <= 2'd2;
            shreg       <= '0;
            pending     <= 1'b0;
            iic_sclk    <= 1'b1;
            sda_low     <= 1'b0;
            iic_ref_clk <= 1'b0;
            go_d        <= 1'b0;
        end else begin
            state       <= state_nx;
            qcnt        <= qtick ? '0 : qcnt + 1'b1;
            quarter     <= quarter_nx;
            bit_cnt     <= bit_nx;
            byte_cnt    <= byte_nx;
            shreg       <= shreg_nx;
            pending     <= pending_nx;
            iic_sclk    <= sclk_nx;
            sda_low     <= sda_low_nx;
            iic_ref_clk <= qtick ? ~iic_ref_clk : iic_ref_clk;
            go_d        <= iic_tr_go;
        end
    end

    always_comb begin
        state_nx   = state;
        quarter_nx = quarter;
        bit_nx     = bit_cnt;
        byte_nx    = byte_cnt;
        shreg_nx   = shreg;
        pending_nx = pending;
        sclk_nx    = iic_sclk;
        sda_low_nx = sda_low;

        if (state == IDLE && go_edge && !pending) begin
            shreg_nx   = iic_data;
            pending_nx = 1'b1;
        end

        // Every line change happens on a qtick; quarter advances and wraps each qtick.
        if (qtick && state != IDLE && state != DONE)
            quarter_nx = quarter + 2'd1;

        case (state)
            IDLE: begin
                sclk_nx    = 1'b1;
                sda_low_nx = 1'b0;
                if (qtick && pending) begin
                    state_nx   = START;
                    quarter_nx = 2'd0;
                    pending_nx = 1'b0;
                end
            end
            START: if (qtick) begin
                case (quarter)
                    2'd0, 2'd1: begin sclk_nx = 1'b1; sda_low_nx = 1'b0; end
                    2'd2:       sda_low_nx = 1'b1;
                    default: begin
                        sclk_nx  = 1'b0;
                        state_nx = DATA;
                        bit_nx   = 3'd7;
                        byte_nx  = 2'd2;
                    end
                endcase
            end
            DATA: if (qtick) begin
                case (quarter)
                    2'd0: begin sclk_nx = 1'b0; sda_low_nx = ~shreg[23]; end
                    2'd1, 2'd2: sclk_nx = 1'b1;
                    default: begin
                        sclk_nx  = 1'b0;
                        shreg_nx = {shreg[22:0], 1'b0};
                        if (bit_cnt == 3'd0) state_nx = ACK;
                        else                 bit_nx   = bit_cnt - 3'd1;
                    end
                endcase
            end
            ACK: if (qtick) begin
                // The slave's ACK/NACK is not acted on: all three bytes always go out.
                case (quarter)
                    2'd0: begin sclk_nx = 1'b0; sda_low_nx = 1'b0; end
                    2'd1, 2'd2: sclk_nx = 1'b1;
                    default: begin
                        sclk_nx = 1'b0;
                        if (byte_cnt != 2'd0) begin
                            state_nx = DATA;
                            byte_nx  = byte_cnt - 2'd1;
                            bit_nx   = 3'd7;
                        end else begin
                            state_nx = STOP;
                        end
                    end
                endcase
            end
            STOP: if (qtick) begin
                case (quarter)
                    2'd0:       begin sclk_nx = 1'b0; sda_low_nx = 1'b1; end
                    2'd1, 2'd2: begin sclk_nx = 1'b1; sda_low_nx = 1'b1; end
                    default: begin
                        sda_low_nx = 1'b0;
                        state_nx   = DONE;
                    end
                endcase
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_iic_cm.sv
// Directed bench for iic_cm: bus monitor/slave model decodes START, bytes, ACK slots and STOP.
module tb_iic_cm;

    logic        clk_50m = 1'b0;
    logic        rst_n   = 1'b1;
    logic [23:0] iic_data = '0;
    logic        iic_tr_go = 1'b0;
    logic        iic_sclk;
    logic        iic_ref_clk;
    logic        iic_tr_done;
    wire         sda;

    logic        slave_drv = 1'b0;
    logic        ack_en = 1'b0;
    logic        clr = 1'b0;

    pullup (sda);
    assign sda = slave_drv ? 1'b0 : 1'bz;

    iic_cm #(.CLK_FREQ(4_000_000), .SCL_FREQ(100_000)) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .iic_sdata  (sda),
        .iic_sclk   (iic_sclk),
        .iic_ref_clk(iic_ref_clk),
        .iic_data   (iic_data),
        .iic_tr_go  (iic_tr_go),
        .iic_tr_done(iic_tr_done)
    );

    always #5 clk_50m = ~clk_50m;

    int cyc = 0;
    always @(posedge clk_50m) cyc <= cyc + 1;

    // Bus monitor and ACKing slave, sampled on the falling clock edge.
    int          nb = 0, starts = 0, stops = 0, dones = 0, viol = 0, per_err = 0, last_rise = 0;
    logic [23:0] word = '0;
    logic [2:0]  acks = '0;
    logic        scl_p = 1'b1, sda_p = 1'b1;

    always @(negedge clk_50m) begin
        if (clr) begin
            starts = 0; stops = 0; dones = 0; viol = 0; per_err = 0;
            word = '0; acks = '0;
        end
        if (rst_n) begin
            nb = 0;
            slave_drv = 1'b0;
        end else begin
            if (scl_p && iic_sclk && sda_p && !sda) begin starts++; nb = 0; end
            if (scl_p && iic_sclk && !sda_p && sda) stops++;
            if ((iic_sclk != scl_p) && (sda != sda_p)) viol++;
            if (!scl_p && iic_sclk) begin
                if (nb > 0 && (cyc - last_rise) != 40) per_err++;
                last_rise = cyc;
                if (nb < 27) begin
                    if (nb % 9 == 8) acks = {acks[1:0], sda};
                    else             word = {word[22:0], sda};
                end
                nb++;
            end
            if (scl_p && !iic_sclk) slave_drv = ack_en && (nb % 9 == 8) && (nb < 27);
            if (iic_tr_done) dones++;
        end
        scl_p = iic_sclk;
        sda_p = sda;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50m);
            #2;
        end
    endtask

    task automatic clear_mon();
        clr = 1'b1;
        @(negedge clk_50m);
        #1 clr = 1'b0;
        tick(1);
    endtask

    task automatic go_pulse(input logic [23:0] d, output int c0);
        iic_data  = d;
        iic_tr_go = 1'b1;
        c0 = cyc;
        tick(1);
        iic_data = ~d;
        tick(2);
        iic_tr_go = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int lat);
        lat = -1;
        for (int i = 0; i < 2000; i++) begin
            tick(1);
            if (iic_tr_done) begin
                lat = cyc - c0;
                break;
            end
        end
        chk("done_timeout", (lat >= 0) ? 1 : 0, 1);
    endtask

    typedef struct {
        logic [23:0] data;
        logic        ack_en;
        logic [23:0] exp_word;
        logic [2:0]  exp_acks;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int c0, lat, t1, t2;
        logic rc;

        vecs[0] = '{24'h555555, 1'b0, 24'h555555, 3'b111};
        vecs[1] = '{24'h341E00, 1'b1, 24'h341E00, 3'b000};
        vecs[2] = '{24'hA5C3FF, 1'b0, 24'hA5C3FF, 3'b111};
        vecs[3] = '{24'h000001, 1'b1, 24'h000001, 3'b000};
        vecs[4] = '{24'hFFFFFF, 1'b1, 24'hFFFFFF, 3'b000};

        // Reset state
        tick(5);
        chk("rst_scl", int'(iic_sclk), 1);
        chk("rst_sda", int'(sda), 1);
        chk("rst_done", int'(iic_tr_done), 0);
        chk("rst_refclk", int'(iic_ref_clk), 0);
        rst_n = 1'b0;
        tick(3);
        chk("idle_scl", int'(iic_sclk), 1);
        chk("idle_sda", int'(sda), 1);

        // Reference clock half-period of one quarter tick (10 clocks)
        t1 = -1; t2 = -1;
        rc = iic_ref_clk;
        for (int i = 0; i < 40 && t2 < 0; i++) begin
            tick(1);
            if (iic_ref_clk != rc) begin
                rc = iic_ref_clk;
                if (t1 < 0) t1 = cyc; else t2 = cyc;
            end
        end
        chk("refclk_halfper", t2 - t1, 10);

        // Table-driven transactions
        foreach (vecs[k]) begin
            ack_en = vecs[k].ack_en;
            clear_mon();
            go_pulse(vecs[k].data, c0);
            wait_done(c0, lat);
            tick(60);
            chk($sformatf("v%0d_word", k), int'(word), int'(vecs[k].exp_word));
            chk($sformatf("v%0d_acks", k), int'(acks), int'(vecs[k].exp_acks));
            chk($sformatf("v%0d_starts", k), starts, 1);
            chk($sformatf("v%0d_stops", k), stops, 1);
            chk($sformatf("v%0d_dones", k), dones, 1);
            chk($sformatf("v%0d_scl_period", k), per_err, 0);
            chk($sformatf("v%0d_scl_sda_same", k), viol, 0);
            chk($sformatf("v%0d_latency", k), (lat >= 1161 && lat <= 1172) ? 1 : 0, 1);
        end

        // Second go edge while busy is ignored
        ack_en = 1'b1;
        clear_mon();
        go_pulse(24'h12AB34, c0);
        tick(300);
        go_pulse(24'hC0FFEE, t1);
        wait_done(c0, lat);
        tick(1500);
        chk("busy_edge_dones", dones, 1);
        chk("busy_edge_starts", starts, 1);
        chk("busy_edge_word", int'(word), 32'h12AB34);

        // Go level held high does not retrigger
        clear_mon();
        iic_data  = 24'h5AA55A;
        iic_tr_go = 1'b1;
        tick(3000);
        iic_tr_go = 1'b0;
        tick(50);
        chk("held_go_dones", dones, 1);
        chk("held_go_stops", stops, 1);
        chk("held_go_word", int'(word), 32'h5AA55A);

        // Reset during the second byte aborts without a done pulse
        clear_mon();
        go_pulse(24'h0F0F0F, c0);
        for (int i = 0; i < 2000 && nb < 12; i++) tick(1);
        chk("abort_reach_byte1", (nb >= 12) ? 1 : 0, 1);
        rst_n = 1'b1;
        #1;
        chk("abort_scl", int'(iic_sclk), 1);
        chk("abort_sda", int'(sda), 1);
        chk("abort_done", int'(iic_tr_done), 0);
        tick(5);
        rst_n = 1'b0;
        clear_mon();
        tick(1500);
        chk("abort_no_done", dones, 0);
        chk("abort_no_start", starts, 0);

        clear_mon();
        go_pulse(24'h9A0C71, c0);
        wait_done(c0, lat);
        tick(60);
        chk("after_abort_word", int'(word), 32'h9A0C71);
        chk("after_abort_dones", dones, 1);
        chk("after_abort_acks", int'(acks), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
